// File: rtl/pulse_shaper_tx.sv
// pulse_shaper_tx: buffered level requests become line levels held at least HOLD_CYCLES clocks.
// Latency: a request into an idle, empty block reaches dout one clock after acceptance.
// Backpressure: in_ready = !full; PULSE_SHAPER_FIFO_EN selects a DEPTH-entry FIFO, else one holding register.
module pulse_shaper_tx #(
  parameter int HOLD_CYCLES = 3,
  parameter int DEPTH       = 4,
  parameter bit IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_level,
  output logic in_ready,
  output logic dout,
  output logic busy
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (HOLD_CYCLES < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
    $error("pulse_shaper_tx: HOLD_CYCLES must be >= 1 and DEPTH a power of two >= 2");
  end

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          full, empty, head, tail;
  logic          push, pop;

  // Requests matching the newest pending (or current) level would not move the line.
  assign push = in_valid && !full && (in_level != tail);

`ifdef PULSE_SHAPER_FIFO_EN
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DEPTH-1:0] mem_q;
  logic [AW:0]      wr_ptr_q, rd_ptr_q, wr_last;

  assign wr_last = wr_ptr_q - PTR_ONE;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign tail    = empty ? dout_q : mem_q[wr_last[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= in_level;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end
`else
  logic hold_vld_q, hold_lvl_q;

  assign empty = !hold_vld_q;
  assign full  = hold_vld_q;
  assign head  = hold_lvl_q;
  assign tail  = hold_vld_q ? hold_lvl_q : dout_q;

  // push needs an empty register and pop a full one, so they never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_lvl_q <= IDLE_LEVEL;
    end else if (push) begin
      hold_vld_q <= 1'b1;
      hold_lvl_q <= in_level;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          dout_d  = head;
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!empty) begin
            pop    = 1'b1;
            dout_d = head;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = !full;
    busy     = (state_q == S_HOLD) || !empty;
    dout     = dout_q;
  end

endmodule

// File: tb/tb_pulse_shaper_tx.sv
// Bench for pulse_shaper_tx: queue-and-timestamp model checked every cycle, plus directed literal checks.
module tb_pulse_shaper_tx;

  localparam int H     = 3;
  localparam int DEPTH = 4;
  localparam bit IDLE  = 1'b0;
`ifdef PULSE_SHAPER_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_level = 1'b0;
  logic in_ready, dout, busy;

  int n_chk = 0;
  int n_err = 0;

  pulse_shaper_tx #(.HOLD_CYCLES(H), .DEPTH(DEPTH), .IDLE_LEVEL(IDLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_level (in_level),
    .in_ready (in_ready),
    .dout     (dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  logic cap_rst, cap_valid, cap_level;
  always @(posedge clk) begin
    cap_rst   <= rst;
    cap_valid <= in_valid;
    cap_level <= in_level;
  end

  // Model: pending levels in a queue; a level may leave the queue once H edges
  // have passed since the previous dout change.
  logic m_q[$];
  logic m_dout = IDLE;
  int   m_last = -1000;
  int   m_edge = 0;
  bit   m_init = 1'b0;
  int   last_chg = -1000;
  logic prev_dout;
  int   tr_e[$];
  logic tr_v[$];

  always @(negedge clk) begin
    logic tl;
    bit   do_push, do_pop;
    if (cap_rst) begin
      m_q.delete();
      m_dout   = IDLE;
      m_last   = -1000;
      last_chg = -1000;
      m_init   = 1'b1;
    end else if (m_init) begin
      tl      = (m_q.size() != 0) ? m_q[$] : m_dout;
      do_push = cap_valid && (m_q.size() < CAP) && (cap_level != tl);
      do_pop  = (m_q.size() != 0) && (m_edge - m_last >= H);
      if (do_pop) begin
        m_dout = m_q.pop_front();
        m_last = m_edge;
      end
      if (do_push) m_q.push_back(cap_level);
    end
    if (m_init) begin
      chk("dout", dout, m_dout);
      chk("in_ready", in_ready, m_q.size() < CAP);
      chk("busy", busy, (m_q.size() != 0) || (m_edge - m_last < H));
      if (dout !== prev_dout && !cap_rst) begin
        chk("min_spacing", (m_edge - last_chg) >= H, 1);
        tr_e.push_back(m_edge);
        tr_v.push_back(dout);
        last_chg = m_edge;
      end
      prev_dout = dout;
    end
    m_edge++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic lvl);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_level = lvl;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    if (!in_ready) chk("send_ready_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 100) begin
      step();
      w++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic clear_trs();
    tr_e.delete();
    tr_v.delete();
  endtask

  task automatic check_trs(input string nm, input int n, input logic [7:0] vals);
    chk({nm, "_count"}, tr_v.size(), n);
    for (int i = 0; i < n && i < tr_v.size(); i++) begin
      chk($sformatf("%s_val%0d", nm, i), tr_v[i], vals[i]);
      if (i > 0) chk($sformatf("%s_gap%0d", nm, i), tr_e[i] - tr_e[i-1], H);
    end
  endtask

  initial begin
    // Reset state
    steps(2);
    chk("reset_dout", dout, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("model_reset_dout", m_dout, 0);
    rst = 1'b0;
    steps(2);
    clear_trs();

    // Single request: dout one edge after accept, hold spans three edges
    send(1'b1);
    chk("single_dout_at_accept", dout, 0);
    chk("single_busy_pending", busy, 1);
`ifdef PULSE_SHAPER_FIFO_EN
    chk("single_ready_at_accept", in_ready, 1);
`else
    chk("single_ready_at_accept", in_ready, 0);
`endif
    step();
    chk("single_dout_new", dout, 1);
    chk("model_single_dout", m_dout, 1);
    chk("single_busy_1", busy, 1);
    step();
    chk("single_busy_2", busy, 1);
    step();
    chk("single_busy_3", busy, 1);
    step();
    chk("single_idle", busy, 0);
    chk("single_dout_kept", dout, 1);
    check_trs("single", 1, 8'b0000_0001);

    // Request equal to the current level is swallowed
    clear_trs();
    send(1'b1);
    chk("dedup_same_busy", busy, 0);
    chk("dedup_same_ready", in_ready, 1);
    steps(3);
    check_trs("dedup_same", 0, 8'b0);

    // Burst of alternating levels
    clear_trs();
    send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    wait_idle();
    check_trs("burst", 4, 8'b0000_1010);

    // Backpressure: six back-to-back requests, order preserved
    clear_trs();
    send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_busy", busy, 1);
    wait_idle();
    check_trs("backpressure", 6, 8'b0010_1010);

    // Dedup from dout=0: 0,0,1,1 yields a single rise
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("dedup_reset_dout", dout, 0);
    clear_trs();
    send(1'b0);
    send(1'b0);
    send(1'b1);
    send(1'b1);
    wait_idle();
    check_trs("dedup", 1, 8'b0000_0001);

    // Reset in the middle of a hold with requests pending
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(1'b1);
    send(1'b0);
`ifdef PULSE_SHAPER_FIFO_EN
    send(1'b1);
`endif
    chk("midrst_pre_dout", dout, 1);
    chk("midrst_pre_busy", busy, 1);
    clear_trs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_dout", dout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    steps(8);
    chk("midrst_dout_later", dout, 0);
    chk("midrst_busy_later", busy, 0);
    check_trs("midrst", 0, 8'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_shaper_tx.md
# pulse_shaper_tx

Transmit-side line driver that turns a stream of requested logic levels into a clean output waveform in which every level is held for at least `HOLD_CYCLES` clocks. It is the counterpart of the input glitch filters. A shaped line driven by this block, such as emulated joystick, key-matrix or IEC lines looped back into the core or driven off-chip, is never shortened into something a downstream filter would reject. Level requests are buffered, so producers can issue bursts without tracking line timing.

## Interface
- `HOLD_CYCLES`, 3: minimum clocks each `dout` level is held. Must be ≥1. Set ≥ 2× the downstream filter cycle.
- `DEPTH`, 4: request FIFO depth. Power of two, ≥2. Only used with `PULSE_SHAPER_FIFO_EN`.
- `IDLE_LEVEL`, 0: `dout` value after reset.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  level request present.
- `in_level`  in  1  requested line level.
- `in_ready`  out  1  request accepted this cycle when `in_valid && in_ready`.
- `dout`  out  1  shaped line, registered.
- `busy`  out  1  high while in HOLD or while requests are pending.

## Operation
- Request buffer:
  - With the FIFO, the buffer is `DEPTH` entries of 1 bit.
  - Without the FIFO, the buffer is a single holding register (see Configuration).
  - `in_ready = !full`. Computed from registered state; no combinational path from `in_valid`.
- Tail level:
  - If the buffer is non-empty, the tail level is the newest buffered entry.
  - Otherwise it is the current `dout`.
- Handling an accepted request:
  - If the request equals the tail level, it is accepted and discarded (dedup; no entry written).
  - Otherwise it is pushed.
- State machine, two states:
  - IDLE: the hold has expired. If the buffer is non-empty at the edge, pop the head, set `dout <= head`, `cnt <= 0`, and go to HOLD.
  - HOLD: `cnt` increments each cycle.
  - When `cnt == HOLD_CYCLES-1`:
    - If the buffer is non-empty, pop the head, set `dout <= head` and `cnt <= 0`, and stay in HOLD.
    - Otherwise go to IDLE.
- Counter width is `$clog2(HOLD_CYCLES+1)`. `cnt` never exceeds `HOLD_CYCLES-1`.
- Simultaneous push and pop in one cycle is legal. Count is unchanged; pointers both advance. Dedup uses the pre-edge tail.
- `busy = (state == HOLD) || !empty`.

## Timing
- Reset values:
  - `dout = IDLE_LEVEL`, `in_ready = 1`, `busy = 0`.
  - State IDLE, `cnt = 0`, buffer empty.
- Reset mid-operation takes effect at that edge and discards all pending requests. `dout` returns to `IDLE_LEVEL` immediately, even inside a hold.
- Latency: a request accepted at edge N with the block idle and the buffer empty gives `dout` = new level after edge N+1.
- Level spacing: consecutive `dout` changes are exactly `HOLD_CYCLES` clocks apart while the buffer stays non-empty. They are never closer.
- `HOLD_CYCLES = 1`: `dout` may change every clock.
- Full buffer: `in_ready` is low. It rises the cycle after the pop that frees an entry.

## Configuration
- `PULSE_SHAPER_FIFO_EN` defined:
  - `DEPTH`-entry FIFO.
  - `in_ready` low only when all `DEPTH` entries are occupied.
- Not defined:
  - Single-entry holding register; `DEPTH` is ignored.
  - `in_ready` is low whenever that register holds a request.
  - Same dedup and hold timing.

## Test plan
- Reset behaviour: assert `rst` for 2 cycles with `IDLE_LEVEL=0` → `dout=0`, `in_ready=1`, `busy=0`.
- Single request:
  - Stimulus: `HOLD_CYCLES=3`; request level 1 accepted at edge 10.
  - Required: `dout=1` after edge 11, `busy` high through edge 13, IDLE after edge 14.
- Burst:
  - Stimulus: with the FIFO, push 1,0,1,0 on consecutive cycles.
  - Required: `dout` toggles after edges 11, 14, 17, 20. `in_ready` stays high.
- Backpressure:
  - Stimulus: `DEPTH=4`, `HOLD_CYCLES=8`; push 1,0,1,0,1,0 back-to-back.
  - Required: `in_ready` drops once 4 entries are pending. No request is lost, and the output sequence matches the input order. Without the macro, only one request is pending at a time.
- Dedup:
  - Stimulus: with `dout=0` and the buffer empty, push 0, 0, 1, 1.
  - Required: one transition to 1 only.
- Reset mid-hold:
  - Stimulus: assert `rst` at `cnt=1` with 2 entries pending.
  - Required: `dout=IDLE_LEVEL` next cycle, buffer empty, and no further transitions.
